vx_writeback_arb: RTL
=====================

// Module: vx_writeback_arb
// PURPOSE
//   Producer side of the per-slice writeback interface consumed by the issue stage.
//   Collects result beats from NUM_UNITS execute units on valid/ready handshakes.
//   Arbitrates round-robin, holding the grant across multi-beat (sop..eop) packets.
//   Drives one registered writeback beat per cycle; the writeback sink has no backpressure.
// PARAMETERS
//   NUM_UNITS     4    number of execute-unit result ports (>=1)
//   NUM_THREADS   4    lanes per beat
//   XLEN          32   data / PC width
//   NW_BITS       2    warp id width
//   NR_BITS       6    destination register id width
//   UUID_WIDTH    44   instruction uuid width
//   PERF_CTR_BITS 44   perf counter width
//   DATAW = UUID_WIDTH+NW_BITS+NUM_THREADS+XLEN+NR_BITS+NUM_THREADS*XLEN+2 (derived)
// PORTS
//   clk           in   1                  clock
//   reset         in   1                  synchronous, active-high reset
//   in_valid      in   NUM_UNITS          per-unit beat valid
//   in_ready      out  NUM_UNITS          per-unit beat accepted (one-hot or zero)
//   in_data       in   NUM_UNITS*DATAW    unit i at [i*DATAW +: DATAW]; MSB..LSB: uuid,wid,tmask,PC,rd,data,sop,eop
//   wb_valid      out  1                  writeback beat valid
//   wb_data       out  DATAW              writeback beat, same field order as in_data
//   perf_stalls   out  PERF_CTR_BITS      cycles with >=1 valid input not granted
// BEHAVIOUR
//   - Clock/reset: single clock clk; reset is synchronous and active-high.
//   - Reset: wb_valid=0, wb_data=0, perf_stalls=0, rr_ptr=0, lock=0, lock_idx=0; in_ready=0 while reset=1.
//   - Grant, combinational, same cycle as in_valid:
//       unlocked: first i with in_valid[i]=1, scanning rr_ptr, rr_ptr+1, ... mod NUM_UNITS.
//       locked:   grant lock_idx only if in_valid[lock_idx]=1; otherwise no grant.
//   - in_ready = one-hot grant. The unit holds in_valid/in_data stable until in_ready=1.
//   - Fire = in_valid[g] & in_ready[g]. On fire the beat is registered.
//     Next cycle: wb_valid=1, wb_data=in_data[g]. Latency is exactly 1 cycle.
//   - No fire: wb_valid=0 next cycle; wb_data holds its last value (don't-care when wb_valid=0).
//   - Packet lock: a fired beat with eop=0 sets lock=1 and lock_idx=g.
//     A fired beat with eop=1 clears lock. sop is passed through only; it is not used for control.
//   - rr_ptr is updated only on an eop=1 fire, to (g+1) mod NUM_UNITS, wrapping NUM_UNITS-1 -> 0.
//     It is unchanged during a locked packet.
//   - Locked with lock_idx not valid: a bubble (wb_valid=0). Other units stay ungranted; beats are never interleaved.
//   - perf_stalls += 1 in any cycle where some in_valid[i]=1 with in_ready[i]=0. The counter wraps modulo 2^PERF_CTR_BITS.
//   - Reset mid-packet: the lock is dropped and the rest of the packet is discarded by the sink.
//     Arbitration restarts from rr_ptr=0 on the first cycle after reset.
//   - NUM_UNITS=1: rr_ptr is constant 0; in_ready[0]=in_valid[0] when not in reset.
//   - All state is flops; no combinational path from any input to wb_*.
// TESTING
//   T1 reset held 3 cycles, all in_valid=1 -> in_ready=0, wb_valid=0, perf_stalls=0 throughout.
//   T2 only unit2 valid, eop=1, rd=5, data=32'hDEAD_BEEF in all lanes -> in_ready=4'b0100 that cycle.
//      Next cycle: wb_valid=1, rd=5, data=DEADBEEF in every lane.
//   T3 all 4 units valid with eop=1 continuously from reset -> grants 0,1,2,3,0,1.
//      wb_valid=1 every cycle from cycle 1; perf_stalls +1 per cycle.
//   T4 unit1 sends a 3-beat packet (eop=0,0,1) while units 0 and 3 are valid -> unit1 beats emitted back-to-back.
//      Then unit3 is next (rr_ptr=2 gives 3 before 0).
//   T5 same packet, but unit1 drops valid for 2 cycles after beat 1 -> 2 bubbles (wb_valid=0) and no grant to units 0/3.
//      Unit1 then resumes.
//   T6 reset pulsed after beat 1 of a unit1 packet, with units 0 and 1 valid afterwards -> unit0 granted first.
//      Separately: rr_ptr=3 with only unit0 valid -> grant 0, after which rr_ptr=1.

Source files
------------

// File: rtl/vx_writeback_arb_if.sv
// Writeback arbiter bus: per-unit result beats in, one registered writeback beat out.
// The arbiter binds the slave modport; the execute units / bench bind the master modport.
interface vx_writeback_arb_if #(
  parameter int NUM_UNITS     = 4,
  parameter int DATAW         = 218,
  parameter int PERF_CTR_BITS = 44
);
  logic [NUM_UNITS-1:0]       in_valid;
  logic [NUM_UNITS-1:0]       in_ready;
  logic [NUM_UNITS*DATAW-1:0] in_data;
  logic                       wb_valid;
  logic [DATAW-1:0]           wb_data;
  logic [PERF_CTR_BITS-1:0]   perf_stalls;
  logic                       dbg_locked;

  modport master (
    output in_valid, in_data,
    input  in_ready, wb_valid, wb_data, perf_stalls, dbg_locked
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, wb_valid, wb_data, perf_stalls, dbg_locked
  );
endinterface

// File: rtl/vx_writeback_arb.sv
// Round-robin writeback arbiter: grants one execute unit per cycle, keeps the grant
// for the whole sop..eop packet and registers the chosen beat onto the writeback bus.
module vx_writeback_arb #(
  parameter int NUM_UNITS     = 4,
  parameter int NUM_THREADS   = 4,
  parameter int XLEN          = 32,
  parameter int NW_BITS       = 2,
  parameter int NR_BITS       = 6,
  parameter int UUID_WIDTH    = 44,
  parameter int PERF_CTR_BITS = 44
) (
  input logic clk,
  input logic reset,
  vx_writeback_arb_if.slave bus
);
  // Handshake: a unit presents in_valid with stable in_data until it sees in_ready;
  // a beat transfers in the cycle where both are high. The sink never stalls.
  localparam int DATAW = UUID_WIDTH + NW_BITS + NUM_THREADS + XLEN + NR_BITS
                       + NUM_THREADS * XLEN + 2;
  localparam int UIDX  = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t                   state;
  state_t                   state_n;
  logic [UIDX-1:0]          rr_ptr;
  logic [UIDX-1:0]          lock_idx;
  logic [NUM_UNITS-1:0]     grant;
  logic [UIDX-1:0]          gidx;
  logic                     fire;
  logic [DATAW-1:0]         sel_data;
  logic                     sel_eop;
  logic                     stall;
  logic                     wb_valid_q;
  logic [DATAW-1:0]         wb_data_q;
  logic [PERF_CTR_BITS-1:0] perf_q;

  always_comb begin
    int  idx;
    logic found;
    grant = '0;
    gidx  = '0;
    idx   = 0;
    found = 1'b0;
    if (!reset) begin
      if (state == ST_LOCKED) begin
        // Mid-packet: only the owning unit may proceed, otherwise a bubble.
        if (bus.in_valid[lock_idx]) begin
          grant[lock_idx] = 1'b1;
          gidx            = lock_idx;
        end
      end else begin
        for (int i = 0; i < NUM_UNITS; i++) begin
          idx = (int'(rr_ptr) + i) % NUM_UNITS;
          if (!found && bus.in_valid[UIDX'(idx)]) begin
            found             = 1'b1;
            grant[UIDX'(idx)] = 1'b1;
            gidx              = UIDX'(idx);
          end
        end
      end
    end
  end

  assign fire     = |grant;
  assign sel_data = bus.in_data[gidx*DATAW +: DATAW];
  assign sel_eop  = sel_data[0];
  assign stall    = |(bus.in_valid & ~grant);

  always_comb begin
    state_n = state;
    if (fire) begin
      state_n = sel_eop ? ST_IDLE : ST_LOCKED;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      rr_ptr     <= '0;
      lock_idx   <= '0;
      wb_valid_q <= 1'b0;
      wb_data_q  <= '0;
      perf_q     <= '0;
    end else begin
      state      <= state_n;
      wb_valid_q <= fire;
      perf_q     <= perf_q + PERF_CTR_BITS'(stall);
      if (fire) begin
        wb_data_q <= sel_data;
        if (sel_eop) begin
          rr_ptr <= (gidx == UIDX'(NUM_UNITS - 1)) ? '0 : gidx + 1'b1;
        end else begin
          lock_idx <= gidx;
        end
      end
    end
  end

  assign bus.in_ready    = grant;
  assign bus.wb_valid    = wb_valid_q;
  assign bus.wb_data     = wb_data_q;
  assign bus.perf_stalls = perf_q;
  assign bus.dbg_locked  = (state == ST_LOCKED);
endmodule
